// File: rtl/mc68k_bus_cycle_controller_pkg.sv
// +--------------------------------------------------------------------------+
// | mc68k_bus_cycle_controller_pkg: FSM states, wait-counter width and the   |
// | default PROM/SRAM/IO decode constants.               Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

package mc68k_bus_cycle_controller_pkg;

   localparam int c_WAIT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DECODE    = 3'd1,
      S_WAIT      = 3'd2,
      S_STEP_HOLD = 3'd3,
      S_ACK       = 3'd4,
      S_BERR      = 3'd5
   } state_t;

   localparam logic [23:0] c_PROM_BASE = 24'h000000;
   localparam logic [23:0] c_PROM_MASK = 24'hF80000;
   localparam logic [c_WAIT_W-1:0] c_PROM_WAIT = 4'd2;

   localparam logic [23:0] c_SRAM_BASE = 24'h080000;
   localparam logic [23:0] c_SRAM_MASK = 24'hF80000;
   localparam logic [c_WAIT_W-1:0] c_SRAM_WAIT = 4'd0;

   localparam logic [23:0] c_IO_BASE   = 24'hFFF000;
   localparam logic [23:0] c_IO_MASK   = 24'hFFF000;
   localparam logic [c_WAIT_W-1:0] c_IO_WAIT   = 4'd1;

endpackage

`default_nettype wire

// File: rtl/mc68k_bus_cycle_controller_if.sv
// +--------------------------------------------------------------------------+
// | mc68k_bus_cycle_controller_if: CPU strobes/address in, chip selects and  |
// | DTACK/BERR out.                                      Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mc68k_bus_cycle_controller_if #(
   parameter int NUM_REGIONS = 3,
   parameter int ADDR_W      = 24
);
   localparam int RGN_W = $clog2(NUM_REGIONS + 1);

   logic                   RUN_IN;
   logic                   AS_IN;
   logic                   WR_IN;
   logic                   UDS_IN;
   logic                   LDS_IN;
   logic [ADDR_W-1:0]      ADDR_IN;
   logic                   STEPEN_IN;
   logic                   STEP_IN;
   logic [NUM_REGIONS-1:0] CS_U_OUT;
   logic [NUM_REGIONS-1:0] CS_L_OUT;
   logic                   OE_OUT;
   logic                   WE_OUT;
   logic                   DTACK_OUT;
   logic                   BERR_OUT;
   logic [RGN_W-1:0]       REGION_OUT;

   modport master (
      output RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, ADDR_IN, STEPEN_IN, STEP_IN,
      input  CS_U_OUT, CS_L_OUT, OE_OUT, WE_OUT, DTACK_OUT, BERR_OUT, REGION_OUT
   );

   modport slave (
      input  RUN_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, ADDR_IN, STEPEN_IN, STEP_IN,
      output CS_U_OUT, CS_L_OUT, OE_OUT, WE_OUT, DTACK_OUT, BERR_OUT, REGION_OUT
   );

endinterface

`default_nettype wire

// File: rtl/mc68k_bus_cycle_controller_region_match.sv
// +--------------------------------------------------------------------------+
// | mc68k_region_match: combinational priority address matcher, lowest       |
// | index wins on overlap.                               Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc68k_region_match
   import mc68k_bus_cycle_controller_pkg::*;
#(
   parameter int NUM_REGIONS = 3,
   parameter int ADDR_W      = 24,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {c_IO_BASE, c_SRAM_BASE, c_PROM_BASE},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {c_IO_MASK, c_SRAM_MASK, c_PROM_MASK},
   parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 3'b001,
   localparam int RGN_W = $clog2(NUM_REGIONS + 1)
)(
   input  wire logic [ADDR_W-1:0] i_addr,
   output logic                   o_hit,
   output logic [RGN_W-1:0]       o_idx,
   output logic                   o_ro
);

   // Scan from the top so the lowest matching index is the one that sticks.
   always_comb begin
      o_hit = 1'b0;
      o_idx = RGN_W'(NUM_REGIONS);
      o_ro  = 1'b0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((i_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
            o_hit = 1'b1;
            o_idx = RGN_W'(i);
            o_ro  = REGION_RO[i];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mc68k_bus_cycle_controller.sv
// +--------------------------------------------------------------------------+
// | mc68k_bus_cycle_controller: 68000 region decode, wait states, DTACK and  |
// | BERR generation. Optional SINGLE_STEP_EN adds step hold. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc68k_bus_cycle_controller
   import mc68k_bus_cycle_controller_pkg::*;
#(
   parameter int NUM_REGIONS = 3,
   parameter int ADDR_W      = 24,
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = {c_IO_BASE, c_SRAM_BASE, c_PROM_BASE},
   parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK = {c_IO_MASK, c_SRAM_MASK, c_PROM_MASK},
   parameter logic [NUM_REGIONS*c_WAIT_W-1:0] REGION_WAIT = {c_IO_WAIT, c_SRAM_WAIT, c_PROM_WAIT},
   parameter logic [NUM_REGIONS-1:0]          REGION_RO   = 3'b001
)(
   input wire logic MCLK_IN,
   input wire logic RESET_n_IN,
   mc68k_bus_cycle_controller_if.slave bus
);

   localparam int RGN_W = $clog2(NUM_REGIONS + 1);
   localparam logic [RGN_W-1:0] c_NO_REGION = RGN_W'(NUM_REGIONS);

   logic [1:0]             r_as_sync, r_wr_sync, r_uds_sync, r_lds_sync;
   logic                   r_as_d;
   logic                   w_as_s, w_wr_s, w_uds_s, w_lds_s;

   state_t                 r_state;
   logic [RGN_W-1:0]       r_region;
   logic                   r_wr;
   logic [c_WAIT_W-1:0]    r_wait_cnt;
   logic [NUM_REGIONS-1:0] r_cs_u, r_cs_l;
   logic                   r_oe, r_we, r_dtack, r_berr;

   logic                   w_hit, w_ro;
   logic [RGN_W-1:0]       w_idx;
   logic [c_WAIT_W-1:0]    w_wait;
   logic [RGN_W-1:0]       w_sel_rgn;
   logic                   w_sel_wr;
   logic [NUM_REGIONS-1:0] w_cs_u, w_cs_l;
   logic                   w_oe, w_we;

   always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
      if (!RESET_n_IN) begin
         r_as_sync  <= '0;
         r_wr_sync  <= '0;
         r_uds_sync <= '0;
         r_lds_sync <= '0;
         r_as_d     <= 1'b0;
      end else begin
         r_as_sync  <= {r_as_sync[0],  bus.AS_IN};
         r_wr_sync  <= {r_wr_sync[0],  bus.WR_IN};
         r_uds_sync <= {r_uds_sync[0], bus.UDS_IN};
         r_lds_sync <= {r_lds_sync[0], bus.LDS_IN};
         r_as_d     <= w_as_s;
      end
   end

   assign w_as_s  = r_as_sync[1];
   assign w_wr_s  = r_wr_sync[1];
   assign w_uds_s = r_uds_sync[1];
   assign w_lds_s = r_lds_sync[1];

`ifdef SINGLE_STEP_EN
   logic [1:0] r_stepen_sync;
   logic [2:0] r_step_sync;
   logic       w_step_active, w_step_rise;

   always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
      if (!RESET_n_IN) begin
         r_stepen_sync <= '0;
         r_step_sync   <= '0;
      end else begin
         r_stepen_sync <= {r_stepen_sync[0], bus.STEPEN_IN};
         r_step_sync   <= {r_step_sync[1:0], bus.STEP_IN};
      end
   end

   assign w_step_active = r_stepen_sync[1];
   assign w_step_rise   = r_step_sync[1] & ~r_step_sync[2];
`endif

   mc68k_region_match #(
      .NUM_REGIONS (NUM_REGIONS),
      .ADDR_W      (ADDR_W),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK),
      .REGION_RO   (REGION_RO)
   ) u_match (
      .i_addr (bus.ADDR_IN),
      .o_hit  (w_hit),
      .o_idx  (w_idx),
      .o_ro   (w_ro)
   );

   always_comb begin
      w_wait = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (w_idx == RGN_W'(i)) w_wait = REGION_WAIT[i*c_WAIT_W +: c_WAIT_W];
      end
   end

   // During DECODE the region/direction are not latched yet, so lanes use the live match.
   always_comb begin
      w_sel_rgn = (r_state == S_DECODE) ? w_idx  : r_region;
      w_sel_wr  = (r_state == S_DECODE) ? w_wr_s : r_wr;
      w_cs_u    = '0;
      w_cs_l    = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (w_sel_rgn == RGN_W'(i)) begin
            w_cs_u[i] = w_uds_s;
            w_cs_l[i] = w_lds_s;
         end
      end
      w_oe = ~w_sel_wr;
      w_we = w_sel_wr & (w_uds_s | w_lds_s);
   end

   always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
      if (!RESET_n_IN) begin
         r_state    <= S_IDLE;
         r_region   <= c_NO_REGION;
         r_wr       <= 1'b0;
         r_wait_cnt <= '0;
         r_cs_u     <= '0;
         r_cs_l     <= '0;
         r_oe       <= 1'b0;
         r_we       <= 1'b0;
         r_dtack    <= 1'b0;
         r_berr     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_as_s && !r_as_d && bus.RUN_IN) r_state <= S_DECODE;
            end

            S_DECODE: begin
               r_region   <= w_idx;
               r_wr       <= w_wr_s;
               r_wait_cnt <= w_wait;
               if (!w_hit || (w_wr_s && w_ro)) begin
                  r_state <= S_BERR;
                  r_berr  <= 1'b1;
               end else begin
                  r_state <= S_WAIT;
                  r_cs_u  <= w_cs_u;
                  r_cs_l  <= w_cs_l;
                  r_oe    <= w_oe;
                  r_we    <= w_we;
               end
            end

            S_WAIT: begin
               if (!w_as_s) begin
                  r_state <= S_IDLE;
                  r_cs_u  <= '0;
                  r_cs_l  <= '0;
                  r_oe    <= 1'b0;
                  r_we    <= 1'b0;
               end else begin
                  r_cs_u <= w_cs_u;
                  r_cs_l <= w_cs_l;
                  r_oe   <= w_oe;
                  r_we   <= w_we;
                  if (r_wait_cnt == '0) begin
`ifdef SINGLE_STEP_EN
                     if (w_step_active) begin
                        r_state <= S_STEP_HOLD;
                     end else begin
                        r_state <= S_ACK;
                        r_dtack <= 1'b1;
                     end
`else
                     r_state <= S_ACK;
                     r_dtack <= 1'b1;
`endif
                  end else begin
                     r_wait_cnt <= r_wait_cnt - 1'b1;
                  end
               end
            end

`ifdef SINGLE_STEP_EN
            S_STEP_HOLD: begin
               if (!w_as_s) begin
                  r_state <= S_IDLE;
                  r_cs_u  <= '0;
                  r_cs_l  <= '0;
                  r_oe    <= 1'b0;
                  r_we    <= 1'b0;
               end else begin
                  r_cs_u <= w_cs_u;
                  r_cs_l <= w_cs_l;
                  r_oe   <= w_oe;
                  r_we   <= w_we;
                  if (w_step_rise) begin
                     r_state <= S_ACK;
                     r_dtack <= 1'b1;
                  end
               end
            end
`endif

            S_ACK: begin
               if (!w_as_s) begin
                  r_state <= S_IDLE;
                  r_cs_u  <= '0;
                  r_cs_l  <= '0;
                  r_oe    <= 1'b0;
                  r_we    <= 1'b0;
                  r_dtack <= 1'b0;
               end else begin
                  r_cs_u <= w_cs_u;
                  r_cs_l <= w_cs_l;
                  r_oe   <= w_oe;
                  r_we   <= w_we;
               end
            end

            S_BERR: begin
               if (!w_as_s) begin
                  r_state <= S_IDLE;
                  r_berr  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cs_u  <= '0;
               r_cs_l  <= '0;
               r_oe    <= 1'b0;
               r_we    <= 1'b0;
               r_dtack <= 1'b0;
               r_berr  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.CS_U_OUT   = r_cs_u;
   assign bus.CS_L_OUT   = r_cs_l;
   assign bus.OE_OUT     = r_oe;
   assign bus.WE_OUT     = r_we;
   assign bus.DTACK_OUT  = r_dtack;
   assign bus.BERR_OUT   = r_berr;
   assign bus.REGION_OUT = r_region;

endmodule

`default_nettype wire

// File: tb/tb_mc68k_bus_cycle_controller.sv
// +--------------------------------------------------------------------------+
// | tb_mc68k_bus_cycle_controller: directed and random bus cycles against a  |
// | deadline-based reference model.                      Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mc68k_bus_cycle_controller;

   localparam int NR = 3;
   localparam int AW = 24;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mc68k_bus_cycle_controller_if #(.NUM_REGIONS(NR), .ADDR_W(AW)) bus ();

   mc68k_bus_cycle_controller #(.NUM_REGIONS(NR), .ADDR_W(AW)) dut (
      .MCLK_IN    (clk),
      .RESET_n_IN (rst_n),
      .bus        (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [AW-1:0] m_base [NR] = '{24'h000000, 24'h080000, 24'hFFF000};
   logic [AW-1:0] m_mask [NR] = '{24'hF80000, 24'hF80000, 24'hFFF000};
   int            m_wait [NR] = '{2, 0, 1};
   bit            m_ro   [NR] = '{1'b1, 1'b0, 1'b0};

   // Model: inputs seen through a 2-sample delay; DTACK due at a computed edge number.
   logic [1:0] h_as, h_wr, h_uds, h_lds, h_sten;
   logic [2:0] h_step;
   logic       m_as_prev, m_as_s, m_wr_s, m_uds_s, m_lds_s, m_stepen_s, m_step_rise;
   int         m_mode;        // 0 idle, 1 decoding, 2 selected, 3 bus error
   longint     m_now, m_ack_edge;
   bit         m_hold, m_wr;
   int         m_idx;
   logic [NR-1:0] e_cs_u, e_cs_l;
   logic       e_oe, e_we, e_dtack, e_berr;
   logic [1:0] e_region;

   function automatic logic [NR-1:0] lane(input int rgn, input logic en);
      logic [NR-1:0] v;
      v = '0;
      if (rgn < NR) v[rgn] = en;
      return v;
   endfunction

   task automatic m_drive_lanes();
      e_cs_u = lane(int'(e_region), m_uds_s);
      e_cs_l = lane(int'(e_region), m_lds_s);
      e_oe   = !m_wr;
      e_we   = m_wr && (m_uds_s || m_lds_s);
   endtask

   task automatic m_clear();
      e_cs_u = '0; e_cs_l = '0; e_oe = 1'b0; e_we = 1'b0; e_dtack = 1'b0; e_berr = 1'b0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_as = '0; h_wr = '0; h_uds = '0; h_lds = '0; h_sten = '0; h_step = '0;
         m_as_prev = 1'b0; m_mode = 0; m_now = 0; m_ack_edge = 0; m_hold = 1'b0; m_wr = 1'b0;
         e_region = 2'd3;
         m_clear();
      end else begin
         m_as_s  = h_as[1];
         m_wr_s  = h_wr[1];
         m_uds_s = h_uds[1];
         m_lds_s = h_lds[1];
`ifdef SINGLE_STEP_EN
         m_stepen_s  = h_sten[1];
         m_step_rise = h_step[1] && !h_step[2];
`else
         m_stepen_s  = 1'b0;
         m_step_rise = 1'b0;
`endif
         m_now++;
         case (m_mode)
            0: if (m_as_s && !m_as_prev && bus.RUN_IN) m_mode = 1;
            1: begin
               m_idx = NR;
               for (int i = NR - 1; i >= 0; i--)
                  if ((bus.ADDR_IN & m_mask[i]) == m_base[i]) m_idx = i;
               e_region = 2'(m_idx);
               m_wr = m_wr_s;
               if (m_idx == NR || (m_wr_s && m_ro[m_idx])) begin
                  m_mode = 3;
                  e_berr = 1'b1;
               end else begin
                  m_mode = 2;
                  m_hold = 1'b0;
                  m_ack_edge = m_now + 1 + m_wait[m_idx];
                  m_drive_lanes();
               end
            end
            2: begin
               if (!m_as_s) begin
                  m_mode = 0;
                  m_clear();
               end else begin
                  m_drive_lanes();
                  if (!e_dtack && !m_hold && m_now == m_ack_edge) begin
                     if (m_stepen_s) m_hold = 1'b1;
                     else            e_dtack = 1'b1;
                  end else if (m_hold && m_step_rise) begin
                     e_dtack = 1'b1;
                     m_hold  = 1'b0;
                  end
               end
            end
            default: if (!m_as_s) begin m_mode = 0; e_berr = 1'b0; end
         endcase
         m_as_prev = m_as_s;
         h_as   = {h_as[0],   bus.AS_IN};
         h_wr   = {h_wr[0],   bus.WR_IN};
         h_uds  = {h_uds[0],  bus.UDS_IN};
         h_lds  = {h_lds[0],  bus.LDS_IN};
         h_sten = {h_sten[0], bus.STEPEN_IN};
         h_step = {h_step[1:0], bus.STEP_IN};
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         n_tests++;
         if (bus.CS_U_OUT !== e_cs_u || bus.CS_L_OUT !== e_cs_l || bus.OE_OUT !== e_oe ||
             bus.WE_OUT !== e_we || bus.DTACK_OUT !== e_dtack || bus.BERR_OUT !== e_berr ||
             (m_mode != 0 && bus.REGION_OUT !== e_region)) begin
            n_fail++;
            $display("FAIL model t=%0t got csu=%b csl=%b oe=%b we=%b dtack=%b berr=%b rgn=%0d exp csu=%b csl=%b oe=%b we=%b dtack=%b berr=%b rgn=%0d",
                     $time, bus.CS_U_OUT, bus.CS_L_OUT, bus.OE_OUT, bus.WE_OUT, bus.DTACK_OUT, bus.BERR_OUT, bus.REGION_OUT,
                     e_cs_u, e_cs_l, e_oe, e_we, e_dtack, e_berr, e_region);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {bus.CS_U_OUT, bus.CS_L_OUT, bus.OE_OUT, bus.WE_OUT, bus.DTACK_OUT, bus.BERR_OUT};
   endfunction

   // Starts a cycle; lat = negedges from AS assertion until DTACK or BERR (0 = never).
   task automatic run_cycle(input logic [23:0] a, input logic wr, input logic u, input logic l, output int lat);
      @(negedge clk);
      bus.ADDR_IN = a; bus.WR_IN = wr; bus.UDS_IN = u; bus.LDS_IN = l; bus.AS_IN = 1'b1;
      lat = 0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk);
         if (bus.DTACK_OUT || bus.BERR_OUT) lat = n;
      end
   endtask

   task automatic release_bus(input string name, input logic hold_dtack, input logic hold_berr);
      @(negedge clk);
      bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0; bus.WR_IN = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({name, "_held"}, {30'd0, bus.DTACK_OUT, bus.BERR_OUT}, {30'd0, hold_dtack, hold_berr});
      @(negedge clk);
      check({name, "_idle"}, {22'd0, outs()}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   logic [23:0] addr_pool [10] = '{24'h000000, 24'h07FFFF, 24'h000100, 24'h080000, 24'h0FFFFF,
                                   24'h100000, 24'h400000, 24'hFFF000, 24'hFFFFFF, 24'hFFEFFF};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit seen;
      bus.RUN_IN = 1'b1; bus.AS_IN = 1'b0; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
      bus.ADDR_IN = '0; bus.STEPEN_IN = 1'b0; bus.STEP_IN = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", {22'd0, outs()}, 32'd0);
      check("reset_region", {30'd0, bus.REGION_OUT}, 32'd3);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      run_cycle(24'h000100, 1'b0, 1'b1, 1'b1, lat);
      check("rd_prom_lat", lat, 7);
      check("rd_prom_cs", {26'd0, bus.CS_U_OUT, bus.CS_L_OUT}, {26'd0, 3'b001, 3'b001});
      check("rd_prom_oewe", {30'd0, bus.OE_OUT, bus.WE_OUT}, 32'b10);
      release_bus("rd_prom", 1'b1, 1'b0);

      run_cycle(24'h080010, 1'b1, 1'b1, 1'b1, lat);
      check("wr_sram_lat", lat, 5);
      check("wr_sram_sig", {22'd0, outs()}, {22'd0, 3'b010, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0});
      release_bus("wr_sram", 1'b1, 1'b0);

      run_cycle(24'h000010, 1'b1, 1'b1, 1'b1, lat);
      check("wr_ro_lat", lat, 4);
      check("wr_ro_sig", {22'd0, outs()}, 32'b1);
      check("wr_ro_region", {30'd0, bus.REGION_OUT}, 32'd0);
      release_bus("wr_ro", 1'b0, 1'b1);

      run_cycle(24'h400000, 1'b0, 1'b1, 1'b1, lat);
      check("unmapped_lat", lat, 4);
      check("unmapped_sig", {22'd0, outs()}, 32'b1);
      check("unmapped_region", {30'd0, bus.REGION_OUT}, 32'd3);
      release_bus("unmapped", 1'b0, 1'b1);

      run_cycle(24'hFFF001, 1'b1, 1'b0, 1'b1, lat);
      check("wr_io_lat", lat, 6);
      check("wr_io_sig", {22'd0, outs()}, {22'd0, 3'b000, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0});
      release_bus("wr_io", 1'b1, 1'b0);

      // Abort: AS dropped while the PROM read is still counting wait states.
      @(negedge clk);
      bus.ADDR_IN = 24'h000200; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b1; bus.LDS_IN = 1'b1; bus.AS_IN = 1'b1;
      repeat (4) @(negedge clk);
      bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.DTACK_OUT || bus.BERR_OUT) seen = 1'b1;
      end
      check("abort_no_ack", {31'd0, seen}, 32'd0);
      check("abort_idle", {22'd0, outs()}, 32'd0);

      run_cycle(24'hFFF000, 1'b0, 1'b1, 1'b1, lat);
      check("pre_reset_lat", lat, 6);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
      #1;
      check("async_reset_outs", {22'd0, outs()}, 32'd0);
      check("async_reset_region", {30'd0, bus.REGION_OUT}, 32'd3);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_cycle(24'h080000, 1'b0, 1'b1, 1'b0, lat);
      check("post_reset_lat", lat, 5);
      check("post_reset_cs", {26'd0, bus.CS_U_OUT, bus.CS_L_OUT}, {26'd0, 3'b010, 3'b000});
      release_bus("post_reset", 1'b1, 1'b0);

`ifdef SINGLE_STEP_EN
      bus.STEPEN_IN = 1'b1;
      @(negedge clk);
      bus.ADDR_IN = 24'h080000; bus.WR_IN = 1'b0; bus.UDS_IN = 1'b1; bus.LDS_IN = 1'b1; bus.AS_IN = 1'b1;
      repeat (5) @(negedge clk);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.DTACK_OUT || bus.CS_U_OUT != 3'b010) seen = 1'b1;
      end
      check("step_hold", {31'd0, seen}, 32'd0);
      bus.STEP_IN = 1'b1;
      lat = 0;
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         @(negedge clk);
         bus.STEP_IN = 1'b0;
         if (bus.DTACK_OUT) lat = n;
      end
      check("step_lat", lat, 3);
      bus.STEPEN_IN = 1'b0;
      release_bus("step", 1'b1, 1'b0);
`endif

      for (int t = 0; t < 150; t++) begin
         int hold;
         @(negedge clk);
         bus.RUN_IN  = ($urandom_range(0, 9) != 0);
         bus.ADDR_IN = ($urandom_range(0, 4) == 0) ? 24'($urandom) : addr_pool[$urandom_range(0, 9)];
         bus.WR_IN   = 1'($urandom);
         bus.UDS_IN  = 1'($urandom);
         bus.LDS_IN  = 1'($urandom);
         bus.AS_IN   = 1'b1;
         hold = $urandom_range(1, 14);
         for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.RUN_IN = ~bus.RUN_IN;
         end
         bus.AS_IN = 1'b0; bus.UDS_IN = 1'b0; bus.LDS_IN = 1'b0;
         repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
